fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch (IF) stage of the core.
- Generates the PC and issues single-outstanding requests on the instruction bus.
- Presents the fetched PC/instruction to the IF/ID pipeline register, and honours stall/flush from the pipeline controller.
- Implements MIPS delay-slot redirect: a taken branch resolved in ID takes effect after the instruction currently in IF.

Parameters:
- ADDR_WIDTH, 32, PC/bus address width.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 32'hbfc00000, PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  exception/eret redirect from controller.
- flush_pc  in  ADDR_WIDTH  redirect target for flush.
- branch_taken  in  1  taken branch resolved in ID (single-cycle pulse).
- branch_target  in  ADDR_WIDTH  branch target.
- stall_current_stage  in  1  IF stalled; fetched instruction must not be consumed.
- rom_req  out  1  instruction request.
- rom_addr  out  ADDR_WIDTH  request address (= pc).
- rom_ready  in  1  request accepted this cycle.
- rom_rvalid  in  1  response valid.
- rom_rdata  in  INST_WIDTH  response instruction.
- stall_request  out  1  IF has no valid instruction; controller must stall.
- if_valid  out  1  if_pc/if_inst valid this cycle.
- if_pc  out  ADDR_WIDTH  PC of presented instruction.
- if_inst  out  INST_WIDTH  presented instruction.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, pc=RESET_PC, buffer=0, redirect_pending=0.
  - Outputs: rom_req=0, if_valid=0, if_pc=RESET_PC, if_inst=0, stall_request=1.
  - Reset mid-transaction abandons the outstanding request; any rom_rvalid seen in IDLE is ignored.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: rom_req=1, rom_addr=pc.
    - rom_ready=1 -> WAIT, or DISCARD if flush is asserted the same cycle.
    - flush with rom_ready=0 -> pc<=flush_pc, stay REQ. rom_addr changes only on acceptance or flush.
  - WAIT: awaiting rom_rvalid.
    - rvalid & flush -> pc<=flush_pc, REQ; data dropped, if_valid=0.
    - rvalid & stall_current_stage -> buffer<=rom_rdata, HOLD.
    - rvalid & !stall -> consumed; pc<=next_pc, REQ.
    - flush without rvalid -> DISCARD, pc<=flush_pc.
  - HOLD: if_inst=buffer.
    - flush -> pc<=flush_pc, REQ.
    - !stall_current_stage -> consumed; pc<=next_pc, REQ.
  - DISCARD: waits for the stale rvalid, drops it, then REQ. A further flush updates pc.
- Presentation:
  - if_valid = (WAIT & rom_rvalid & !flush) | (HOLD & !flush).
  - if_inst = HOLD ? buffer : rom_rdata.
  - if_pc = pc.
- stall_request = REQ | DISCARD | IDLE | (WAIT & !rom_rvalid). It depends only on state and rom_rvalid, never on stall/flush inputs, so there is no combinational loop with the controller.
- next_pc:
  - redirect_pending ? redirect_target : pc+4, with the +4 modulo 2^ADDR_WIDTH (wraps silently).
  - redirect_pending clears when consumed.
- Branch:
  - branch_taken (any state) sets redirect_pending, redirect_target<=branch_target.
  - Branch and consumption in the same cycle: next_pc = branch_target directly, pending stays 0.
  - The instruction in IF at that moment (delay slot) is still delivered.
- Flush:
  - Priority flush > branch > sequential.
  - Flush clears redirect_pending, including a same-cycle branch_taken.
- Throughput: at most one instruction per 2 cycles (REQ, then WAIT with rvalid); zero-latency bus gives 2-cycle cadence.

Decomposition:
- Shared header/package:
  - Fetch state encoding (IDLE, REQ, WAIT, HOLD, DISCARD; 3 bits).
  - RESET_PC default.
  - Instruction-bus width constants.
- One natural sub-module: fetch_pc_sel, the combinational next_pc/redirect-target mux with flush/branch priority. The FSM stays in fetch_unit.

Test Plan:
- Reset release, bus rom_ready=1 always, rvalid one cycle after accept -> rom_addr sequence bfc00000, bfc00004, bfc00008; if_valid every 2nd cycle; stall_request low only on rvalid cycles.
- stall_current_stage=1 for 3 cycles when rvalid arrives with 0x24020001 -> HOLD; if_inst stays 0x24020001, if_valid=1 throughout; no new rom_req until stall drops; next rom_addr = pc+4.
- branch_taken target 0x80001000 while fetching bfc00004 -> bfc00004 delivered (delay slot), next rom_addr=0x80001000.
- flush (flush_pc=0xbfc00380) in WAIT before rvalid -> DISCARD; the stale rvalid produces if_valid=0; next rom_addr=bfc00380.
- Same-cycle branch_taken and flush -> flush wins; rom_addr=flush_pc, no later branch redirect.
- rst pulled low while in WAIT, rvalid arriving during IDLE -> ignored; first request after release at RESET_PC. Also pc=ffff_fffc sequential -> next rom_addr=0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - fetch FSM state encoding (3 bits)
//   - default reset PC and instruction-bus widths
package fetch_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_DISCARD = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_sel.sv
// fetch_pc_sel: combinational PC selection for the fetch stage.
// Chooses the value to load into pc (flush > branch > pending redirect > pc+4)
// and the next value of the delay-slot redirect bookkeeping.
// Ports:
//   pc, redirect_pending, redirect_target : current fetch state
//   flush, flush_pc                       : controller redirect
//   branch_taken, branch_target           : branch resolved in ID
//   consume                               : presented instruction taken this cycle
//   sel_pc                                : value for pc when it is updated
//   pending_nxt, target_nxt               : next redirect bookkeeping
module fetch_pc_sel #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  redirect_pending,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  consume,
  output logic [ADDR_WIDTH-1:0] sel_pc,
  output logic                  pending_nxt,
  output logic [ADDR_WIDTH-1:0] target_nxt
);

  logic [ADDR_WIDTH-1:0] seq_pc;

  always_comb begin
    // +4 wraps modulo 2^ADDR_WIDTH
    seq_pc = redirect_pending ? redirect_target : pc + ADDR_WIDTH'(4);
    // A branch arriving with the delay-slot consumption redirects immediately
    if (branch_taken) seq_pc = branch_target;
    sel_pc = flush ? flush_pc : seq_pc;
  end

  always_comb begin
    pending_nxt = redirect_pending;
    target_nxt  = redirect_target;
    if (flush) begin
      pending_nxt = 1'b0;
    end else if (branch_taken) begin
      pending_nxt = ~consume;
      target_nxt  = branch_target;
    end else if (consume) begin
      pending_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch (IF) stage.
// Generates the PC, issues single-outstanding requests on the instruction
// bus and presents PC/instruction to the IF/ID register. Supports stall,
// flush and MIPS delay-slot branch redirect.
// Ports:
//   clk, rst (async, active low)
//   flush/flush_pc, branch_taken/branch_target, stall_current_stage : control
//   rom_req/rom_addr/rom_ready/rom_rvalid/rom_rdata                 : bus
//   stall_request, if_valid, if_pc, if_inst                         : to pipeline
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = ADDR_W,
  parameter int unsigned          INST_WIDTH = INST_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  stall_current_stage,
  output logic                  rom_req,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_ready,
  input  logic                  rom_rvalid,
  input  logic [INST_WIDTH-1:0] rom_rdata,
  output logic                  stall_request,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [INST_WIDTH-1:0] if_inst
);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [INST_WIDTH-1:0] buffer;
  logic                  redirect_pending;
  logic [ADDR_WIDTH-1:0] redirect_target;

  logic                  consume;
  logic [ADDR_WIDTH-1:0] sel_pc;
  logic                  pending_nxt;
  logic [ADDR_WIDTH-1:0] target_nxt;

  always_comb begin
    consume = 1'b0;
    if (!flush && !stall_current_stage) begin
      consume = (state == S_WAIT && rom_rvalid) || (state == S_HOLD);
    end
  end

  fetch_pc_sel #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc_sel (
    .pc              (pc),
    .redirect_pending(redirect_pending),
    .redirect_target (redirect_target),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .consume         (consume),
    .sel_pc          (sel_pc),
    .pending_nxt     (pending_nxt),
    .target_nxt      (target_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      pc               <= RESET_PC;
      buffer           <= '0;
      redirect_pending <= 1'b0;
      redirect_target  <= '0;
    end else begin
      redirect_pending <= pending_nxt;
      redirect_target  <= target_nxt;
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (flush) pc <= sel_pc;
          // An accepted request that is flushed must still have its response drained
          if (rom_ready) state <= flush ? S_DISCARD : S_WAIT;
        end
        S_WAIT: begin
          if (rom_rvalid) begin
            if (flush) begin
              pc    <= sel_pc;
              state <= S_REQ;
            end else if (stall_current_stage) begin
              buffer <= rom_rdata;
              state  <= S_HOLD;
            end else begin
              pc    <= sel_pc;
              state <= S_REQ;
            end
          end else if (flush) begin
            pc    <= sel_pc;
            state <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (flush || !stall_current_stage) begin
            pc    <= sel_pc;
            state <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (flush) pc <= sel_pc;
          if (rom_rvalid) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rom_req  = (state == S_REQ);
  assign rom_addr = pc;
  assign if_pc    = pc;

  // Depends only on state and rom_rvalid so the controller sees no loop
  assign stall_request = (state == S_REQ) || (state == S_DISCARD) || (state == S_IDLE) ||
                         (state == S_WAIT && !rom_rvalid);

  assign if_valid = !flush && ((state == S_WAIT && rom_rvalid) || (state == S_HOLD));

  always_comb begin
    if_inst = '0;
    if (state == S_HOLD)      if_inst = buffer;
    else if (state == S_WAIT) if_inst = rom_rdata;
  end

endmodule
